fetch_parcel_stage: RTL and testbench



---
 rtl/fetch_parcel_stage_pkg.sv | 14 +
 rtl/fetch_parcel_stage_if.sv | 33 +++
 rtl/fetch_parcel_stage_parcel_select.sv | 23 ++
 rtl/fetch_parcel_stage.sv | 95 +++++++++
 tb/tb_fetch_parcel_stage.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_parcel_stage_pkg.sv
// fetch_parcel_stage_pkg: shared parcel, lane and state types for the parcel fetch stage.
package fetch_parcel_stage_pkg;
    localparam int PARCEL_WIDTH = 16;
    localparam int LANE_PC_WIDTH = 32;
    typedef logic [PARCEL_WIDTH-1:0] parcel_t;
    typedef enum logic {EMPTY, HOLD} fetch_state_e;
    typedef struct packed {
        logic [LANE_PC_WIDTH-1:0] pc;
        parcel_t parcel;
        logic fault;
        logic irq_valid;
        logic [3:0] irq_code;
    } wr_lane_t;
endpackage

// File: rtl/fetch_parcel_stage_if.sv
// fetch_parcel_stage_if: line input, controller and instruction-buffer write bundle of the fetch parcel stage.
interface fetch_parcel_stage_if #(
    parameter int LINE_WIDTH = 128,
    parameter int WRITE_PORTS = 4,
    parameter int ADDR_WIDTH = 32
);
    localparam int CW = $clog2(WRITE_PORTS + 1);
    logic line_valid;
    logic line_ready;
    logic [ADDR_WIDTH-1:0] line_pc;
    logic [LINE_WIDTH-1:0] line_data;
    logic line_fault;
    logic irq_valid;
    logic [3:0] irq_code;
    logic flush;
    logic stall;
    logic [CW-1:0] buf_free;
    logic [CW-1:0] wr_count;
    logic [WRITE_PORTS*ADDR_WIDTH-1:0] wr_pc;
    logic [WRITE_PORTS*16-1:0] wr_parcel;
    logic [WRITE_PORTS-1:0] wr_fault;
    logic [WRITE_PORTS-1:0] wr_irq_valid;
    logic [WRITE_PORTS*4-1:0] wr_irq_code;
    logic busy;
    modport master (
        output line_valid, line_pc, line_data, line_fault, irq_valid, irq_code, flush, stall, buf_free,
        input line_ready, wr_count, wr_pc, wr_parcel, wr_fault, wr_irq_valid, wr_irq_code, busy
    );
    modport slave (
        input line_valid, line_pc, line_data, line_fault, irq_valid, irq_code, flush, stall, buf_free,
        output line_ready, wr_count, wr_pc, wr_parcel, wr_fault, wr_irq_valid, wr_irq_code, busy
    );
endinterface

// File: rtl/fetch_parcel_stage_parcel_select.sv
// fetch_parcel_stage_parcel_select: rotates the held line so lane i carries parcel offset+i and its PC.
module fetch_parcel_stage_parcel_select
    import fetch_parcel_stage_pkg::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int WRITE_PORTS = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int OW = $clog2(LINE_WIDTH / PARCEL_WIDTH) + 1
) (
    input  logic [LINE_WIDTH-1:0] line,
    input  logic [ADDR_WIDTH-1:0] base,
    input  logic [OW-1:0] offset,
    output logic [WRITE_PORTS*PARCEL_WIDTH-1:0] parcels,
    output logic [WRITE_PORTS*ADDR_WIDTH-1:0] pcs
);
    for (genvar i = 0; i < WRITE_PORTS; i++) begin : g_lane
        logic [OW:0] idx;
        assign idx = {1'b0, offset} + (OW+1)'(i);
        // lanes past the line end read zeros; the stage never counts them
        assign parcels[i*PARCEL_WIDTH +: PARCEL_WIDTH] = parcel_t'(line >> (idx * PARCEL_WIDTH));
        assign pcs[i*ADDR_WIDTH +: ADDR_WIDTH] = base + ADDR_WIDTH'({idx, 1'b0});
    end
endmodule

// File: rtl/fetch_parcel_stage.sv
// fetch_parcel_stage: holds one I-cache line and drains up to WRITE_PORTS tagged parcels per cycle.
// RAFI_FETCH_RVC_EN selects 16-bit parcel granularity; otherwise parcels move as 32-bit pairs.
module fetch_parcel_stage
    import fetch_parcel_stage_pkg::*;
#(
    parameter int LINE_WIDTH = 128,
    parameter int WRITE_PORTS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    fetch_parcel_stage_if.slave bus
);
    localparam int P = LINE_WIDTH / PARCEL_WIDTH;
    localparam int LB = $clog2(P);
    localparam int OW = LB + 1;
    localparam int BW = $clog2(LINE_WIDTH / 8);
    localparam int CW = $clog2(WRITE_PORTS + 1);

    fetch_state_e state, state_d;
    logic [LINE_WIDTH-1:0] line_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [OW-1:0] off_q, off_d, avail, lim, n_all, n, start;
    logic fault_q, irq_v_q;
    logic [3:0] irq_c_q;
    logic go, last, accept;
    logic [CW-1:0] cnt;
    logic unused_pc_lsb;

    assign unused_pc_lsb = bus.line_pc[0];

    always_comb begin
        avail = OW'(P) - off_q;
        lim = avail < OW'(WRITE_PORTS) ? avail : OW'(WRITE_PORTS);
        n_all = OW'(bus.buf_free) < lim ? OW'(bus.buf_free) : lim;
`ifdef RAFI_FETCH_RVC_EN
        n = n_all;
        start = OW'(bus.line_pc[LB:1]);
`else
        n = n_all & ~OW'(1);
        start = OW'(bus.line_pc[LB:1]) & ~OW'(1);
`endif
        go = state == HOLD && !bus.stall && !bus.flush;
        // a faulting line produces exactly one lane-0 write and then retires
        cnt = !go ? '0 : fault_q ? CW'(bus.buf_free != '0) : CW'(n);
        last = go && (fault_q ? bus.buf_free != '0 : off_q + n == OW'(P));
        bus.line_ready = !rst && !bus.flush && (state == EMPTY || last);
        accept = bus.line_valid && bus.line_ready;
        state_d = bus.flush ? EMPTY : accept ? HOLD : last ? EMPTY : state;
        off_d = accept ? start : off_q + OW'(cnt);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= EMPTY;
            off_q <= '0;
            line_q <= '0;
            base_q <= '0;
            fault_q <= 1'b0;
            irq_v_q <= 1'b0;
            irq_c_q <= '0;
        end else begin
            state <= state_d;
            off_q <= off_d;
            if (accept) begin
                line_q <= bus.line_data;
                base_q <= {bus.line_pc[ADDR_WIDTH-1:BW], {BW{1'b0}}};
                fault_q <= bus.line_fault;
                irq_v_q <= bus.irq_valid;
                irq_c_q <= bus.irq_code;
            end
        end

    fetch_parcel_stage_parcel_select #(
        .LINE_WIDTH(LINE_WIDTH),
        .WRITE_PORTS(WRITE_PORTS),
        .ADDR_WIDTH(ADDR_WIDTH),
        .OW(OW)
    ) u_parcel_select (
        .line(line_q),
        .base(base_q),
        .offset(off_q),
        .parcels(bus.wr_parcel),
        .pcs(bus.wr_pc)
    );

    assign bus.wr_count = cnt;
    assign bus.busy = state == HOLD;
    assign bus.wr_irq_code = {WRITE_PORTS{irq_c_q}};

    for (genvar i = 0; i < WRITE_PORTS; i++) begin : g_tag
        assign bus.wr_fault[i] = fault_q && CW'(i) < cnt;
        assign bus.wr_irq_valid[i] = irq_v_q && CW'(i) < cnt;
    end
endmodule

// File: tb/tb_fetch_parcel_stage.sv
// tb_fetch_parcel_stage: directed and randomized checks of fetch_parcel_stage against a parcel-queue model.
module tb_fetch_parcel_stage;
    import fetch_parcel_stage_pkg::*;
    localparam int LW = 128;
    localparam int WP = 4;
    localparam int AW = 32;
    localparam int P = LW / 16;
`ifdef RAFI_FETCH_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;
    wr_lane_t mq[$];
    int m_n;
    bit m_rdy;
    logic [LW-1:0] pat;

    fetch_parcel_stage_if #(.LINE_WIDTH(LW), .WRITE_PORTS(WP), .ADDR_WIDTH(AW)) bus ();
    fetch_parcel_stage #(.LINE_WIDTH(LW), .WRITE_PORTS(WP), .ADDR_WIDTH(AW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // the remaining parcels of the held line, in write order
    task automatic push_line;
        int s;
        logic [31:0] base;
        wr_lane_t e;
        s = int'(bus.line_pc[3:1]);
        if (!RVC) s = s & ~1;
        base = bus.line_pc & ~32'hF;
        for (int k = s; k < P; k++) begin
            e.pc = base + 32'(2 * k);
            e.parcel = bus.line_data[k*16 +: 16];
            e.fault = bus.line_fault;
            e.irq_valid = bus.irq_valid;
            e.irq_code = bus.irq_code;
            mq.push_back(e);
            if (bus.line_fault) break;
        end
    endtask

    task automatic model_check;
        int sz;
        int n;
        sz = mq.size();
        n = 0;
        if (!rst && !bus.stall && !bus.flush && sz != 0) begin
            n = sz < WP ? sz : WP;
            if (int'(bus.buf_free) < n) n = int'(bus.buf_free);
            if (!RVC && !mq[0].fault) n = n & ~1;
        end
        m_n = n;
        m_rdy = !rst && !bus.flush && (sz == 0 || n == sz);
        chk("line_ready", bus.line_ready, m_rdy);
        chk("busy", bus.busy, sz != 0 && !rst);
        chk("wr_count", bus.wr_count, n);
        for (int i = 0; i < WP; i++) begin
            if (i < n) begin
                chk($sformatf("wr_pc[%0d]", i), bus.wr_pc[i*AW +: AW], mq[i].pc);
                chk($sformatf("wr_parcel[%0d]", i), bus.wr_parcel[i*16 +: 16], mq[i].parcel);
                chk($sformatf("wr_fault[%0d]", i), bus.wr_fault[i], mq[i].fault);
                chk($sformatf("wr_irq_valid[%0d]", i), bus.wr_irq_valid[i], mq[i].irq_valid);
                chk($sformatf("wr_irq_code[%0d]", i), bus.wr_irq_code[i*4 +: 4], mq[i].irq_code);
            end else begin
                chk($sformatf("idle wr_fault[%0d]", i), bus.wr_fault[i], 0);
                chk($sformatf("idle wr_irq_valid[%0d]", i), bus.wr_irq_valid[i], 0);
            end
        end
    endtask

    task automatic model_update;
        if (rst || bus.flush) mq.delete();
        else begin
            repeat (m_n) void'(mq.pop_front());
            if (bus.line_valid && m_rdy) push_line();
        end
    endtask

    task automatic at_neg;
        @(negedge clk);
        model_check();
    endtask

    task automatic at_next;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic present(logic [31:0] pc, bit fault, logic [2:0] bf);
        bus.line_valid = 1'b1;
        bus.line_pc = pc;
        bus.line_fault = fault;
        bus.buf_free = bf;
    endtask

    task automatic lanes(string tag, int cnt, logic [31:0] pc0);
        chk({tag, " wr_count"}, bus.wr_count, cnt);
        for (int i = 0; i < cnt; i++)
            chk($sformatf("%s pc[%0d]", tag, i), bus.wr_pc[i*AW +: AW], pc0 + 32'(2 * i));
    endtask

    initial begin
        for (int k = 0; k < P; k++) pat[k*16 +: 16] = 16'hA000 + 16'(k);
        bus.line_valid = 1'b0;
        bus.line_pc = '0;
        bus.line_data = pat;
        bus.line_fault = 1'b0;
        bus.irq_valid = 1'b1;
        bus.irq_code = 4'h9;
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        bus.buf_free = 3'd4;
        at_neg;
        chk("reset line_ready", bus.line_ready, 0);
        chk("reset wr_count", bus.wr_count, 0);
        chk("reset busy", bus.busy, 0);
        at_next;
        rst = 1'b0;

`ifdef RAFI_FETCH_RVC_EN
        present(32'h1000, 1'b0, 3'd4);
        at_neg; chk("rvc accept ready", bus.line_ready, 1); at_next;
        bus.line_valid = 1'b0;
        at_neg; lanes("rvc t1", 4, 32'h1000);
        chk("rvc t1 parcel3", bus.wr_parcel[3*16 +: 16], 16'hA003); at_next;
        present(32'h100A, 1'b0, 3'd4);
        at_neg; lanes("rvc t2", 4, 32'h1008); chk("rvc t2 ready", bus.line_ready, 1); at_next;
        bus.line_valid = 1'b0;
        at_neg; lanes("rvc odd", 3, 32'h100A); chk("rvc odd ready", bus.line_ready, 1); at_next;
        at_neg; chk("rvc odd busy", bus.busy, 0); at_next;
`else
        present(32'h1000, 1'b0, 3'd3);
        at_neg; chk("pair accept ready", bus.line_ready, 1); at_next;
        bus.line_valid = 1'b0;
        bus.buf_free = 3'd1;
        at_neg; chk("pair free1 wr_count", bus.wr_count, 0); at_next;
        bus.buf_free = 3'd3;
        at_neg; lanes("pair t1", 2, 32'h1000); at_next;
        bus.buf_free = 3'd4;
        at_neg; lanes("pair t2", 4, 32'h1004);
        chk("pair t2 parcel0", bus.wr_parcel[15:0], 16'hA002); at_next;
        present(32'h100A, 1'b0, 3'd4);
        at_neg; lanes("pair t3", 2, 32'h100C); chk("pair t3 ready", bus.line_ready, 1); at_next;
        bus.line_valid = 1'b0;
        at_neg; lanes("pair odd start", 4, 32'h1008); at_next;
        at_neg; chk("pair odd busy", bus.busy, 0); at_next;
`endif

        present(32'h2004, 1'b1, 3'd4);
        at_neg; at_next;
        bus.line_valid = 1'b0;
        bus.line_fault = 1'b0;
        at_neg; lanes("fault", 1, 32'h2004); chk("fault flag", bus.wr_fault[0], 1); at_next;
        at_neg; chk("fault busy", bus.busy, 0); at_next;

        present(32'h3000, 1'b0, 3'd4);
        at_neg; at_next;
        bus.line_valid = 1'b0;
        bus.flush = 1'b1;
        at_neg; chk("flush wr_count", bus.wr_count, 0); chk("flush ready", bus.line_ready, 0); at_next;
        bus.flush = 1'b0;
        at_neg; chk("flush busy", bus.busy, 0); chk("flush ready after", bus.line_ready, 1); at_next;

        present(32'h4000, 1'b0, 3'd2);
        at_neg; at_next;
        bus.line_valid = 1'b0;
        at_neg; lanes("stall pre", 2, 32'h4000); at_next;
        bus.stall = 1'b1;
        repeat (3) begin
            at_neg; chk("stall wr_count", bus.wr_count, 0); at_next;
        end
        bus.stall = 1'b0;
        at_neg; lanes("stall resume", 2, 32'h4004); at_next;
        bus.buf_free = 3'd4;
        repeat (3) begin at_neg; at_next; end

        for (int c = 0; c < 4000; c++) begin
            bus.line_valid = $urandom_range(0, 9) < 7;
            bus.line_pc = $urandom;
            bus.line_data = {$urandom, $urandom, $urandom, $urandom};
            bus.line_fault = $urandom_range(0, 9) == 0;
            bus.irq_valid = $urandom_range(0, 3) == 0;
            bus.irq_code = 4'($urandom);
            bus.flush = $urandom_range(0, 19) == 0;
            bus.stall = $urandom_range(0, 6) == 0;
            bus.buf_free = 3'($urandom_range(0, 4));
            rst = $urandom_range(0, 499) == 0;
            at_neg;
            at_next;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
